// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) register stages, SLL/SRL/SRA, valid/ready on both sides.
// Define BSHIFT_ROTATE_EN to build rotate-right for op 11; otherwise op 11 runs as SRL and reports op 01.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned STG = $clog2(WIDTH),
  localparam int unsigned SHW = STG + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_op
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic             sgn;
    logic             ovf;
    logic [STG-1:0]   shamt;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t     stg_q [STG];
  stage_t     stg_d [STG];
  logic       advance;
  logic [1:0] op0;

  // One fixed-distance step; SRA fills from the sign captured at acceptance.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       op,
                                                  input logic             sgn,
                                                  input int unsigned      amt);
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = sgn ? ~((~d) >> amt) : (d >> amt);
`ifdef BSHIFT_ROTATE_EN
      OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
`endif
      default: r = d >> amt;
    endcase
    return r;
  endfunction

  // A single global stall: every stage moves together or holds together.
  assign advance  = out_ready | ~stg_q[STG-1].vld;
  assign in_ready = advance;

  always_comb begin
    op0 = in_op;
`ifndef BSHIFT_ROTATE_EN
    if (in_op == OP_ROR) op0 = OP_SRL;
`endif
    for (int unsigned k = 0; k < STG; k++) stg_d[k] = '0;

    stg_d[0].vld   = in_valid;
    stg_d[0].op    = op0;
    stg_d[0].sgn   = in_data[WIDTH-1];
    stg_d[0].ovf   = in_shamt[STG];
    stg_d[0].shamt = in_shamt[STG-1:0];
    stg_d[0].tag   = in_tag;
    stg_d[0].data  = in_shamt[0] ? shift_step(in_data, op0, in_data[WIDTH-1], 1) : in_data;

    for (int unsigned k = 1; k < STG; k++) begin
      stg_d[k] = stg_q[k-1];
      if (stg_q[k-1].shamt[k])
        stg_d[k].data = shift_step(stg_q[k-1].data, stg_q[k-1].op, stg_q[k-1].sgn, 32'd1 << k);
    end

    // Shift of WIDTH or more saturates everything except rotate.
    if (stg_d[STG-1].ovf && (stg_d[STG-1].op != OP_ROR))
      stg_d[STG-1].data = (stg_d[STG-1].op == OP_SRA) ? {WIDTH{stg_d[STG-1].sgn}} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STG; k++) stg_q[k] <= '0;
    end else if (advance) begin
      for (int unsigned k = 0; k < STG; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign out_valid = stg_q[STG-1].vld;
  assign out_data  = stg_q[STG-1].data;
  assign out_tag   = stg_q[STG-1].tag;
  assign out_op    = stg_q[STG-1].op;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and model-checked bench for pipelined_barrel_shifter at WIDTH=8 and WIDTH=32.
module tb_pipelined_barrel_shifter;

  localparam int STG8  = 3;
  localparam int STG32 = 5;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] in_shamt, in_tag, out_tag;
  logic [1:0] in_op, out_op;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_data, w_out_data;
  logic [5:0]  w_in_shamt;
  logic [7:0]  w_in_tag, w_out_tag;
  logic [1:0]  w_in_op, w_out_op;

  pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_op(out_op)
  );

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_shamt(w_in_shamt),
    .in_op(w_in_op), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_op(w_out_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] exp_op(input logic [1:0] op);
`ifdef BSHIFT_ROTATE_EN
    return op;
`else
    return (op == 2'd3) ? 2'd1 : op;
`endif
  endfunction

  function automatic logic [31:0] model32(input logic [31:0] d, input logic [5:0] s,
                                         input logic [1:0] op);
    logic [31:0]        r;
    logic signed [31:0] sd;
    logic [4:0]         m;
    m  = s[4:0];
    sd = $signed(d) >>> m;
    case (op)
      2'd0: r = s[5] ? 32'd0 : (d << m);
      2'd2: r = s[5] ? {32{d[31]}} : sd;
`ifdef BSHIFT_ROTATE_EN
      2'd3: r = (d >> m) | (d << (6'd32 - {1'b0, m}));
`endif
      default: r = s[5] ? 32'd0 : (d >> m);
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    checks++; if (out_op !== 2'd0) begin errors++; $display("FAIL reset_out_op: got %0d expected 0", out_op); end
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_w_out_valid: got %b expected 0", w_out_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (w_in_ready !== 1'b1) begin errors++; $display("FAIL reset_w_in_ready: got %b expected 1", w_in_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] sh [4] = '{4'd3, 4'd2, 4'd2, 4'd3};
    logic [1:0] ops [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] ex [4];
    ex[0] = 8'hB0; ex[1] = 8'h25; ex[2] = 8'hE5;
`ifdef BSHIFT_ROTATE_EN
    ex[3] = 8'hD2;
`else
    ex[3] = 8'h12;
`endif
    out_ready = 1'b1;
    for (int j = 0; j < STG8 + 5; j++) begin
      @(negedge clk);
      if (j >= STG8 && j < STG8 + 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", j, out_valid); end
        checks++; if (out_data !== ex[j-STG8]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", j-STG8, out_data, ex[j-STG8]); end
        checks++; if (out_tag !== 4'(j - STG8 + 1)) begin errors++; $display("FAIL basic_tag[%0d]: got %h expected %h", j-STG8, out_tag, 4'(j-STG8+1)); end
        checks++; if (out_op !== exp_op(ops[j-STG8])) begin errors++; $display("FAIL basic_op[%0d]: got %0d expected %0d", j-STG8, out_op, exp_op(ops[j-STG8])); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle[%0d]: got %b expected 0", j, out_valid); end
      end
      if (j < 4) begin
        in_valid = 1'b1; in_data = 8'h96; in_shamt = sh[j]; in_op = ops[j]; in_tag = 4'(j + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // In-range maximum shift (7), out-of-range (9) and exactly WIDTH (8).
  task automatic test_out_of_range();
    localparam int N = 9;
    logic [3:0] sh [N] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
    logic [1:0] ops [N] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [7:0] ex [N];
    ex[0] = 8'h00; ex[1] = 8'h01; ex[2] = 8'hFF;
    ex[4] = 8'h00; ex[5] = 8'h00; ex[6] = 8'hFF;
`ifdef BSHIFT_ROTATE_EN
    ex[3] = 8'h2D; ex[7] = 8'h4B; ex[8] = 8'h96;
`else
    ex[3] = 8'h01; ex[7] = 8'h00; ex[8] = 8'h00;
`endif
    out_ready = 1'b1;
    for (int j = 0; j < STG8 + N + 1; j++) begin
      @(negedge clk);
      if (j >= STG8 && j < STG8 + N) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL oor_valid[%0d]: got %b expected 1", j-STG8, out_valid); end
        checks++; if (out_data !== ex[j-STG8]) begin errors++; $display("FAIL oor_data[%0d]: got %h expected %h", j-STG8, out_data, ex[j-STG8]); end
        checks++; if (out_op !== exp_op(ops[j-STG8])) begin errors++; $display("FAIL oor_op[%0d]: got %0d expected %0d", j-STG8, out_op, exp_op(ops[j-STG8])); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL oor_idle[%0d]: got %b expected 0", j, out_valid); end
      end
      if (j < N) begin
        in_valid = 1'b1; in_data = 8'h96; in_shamt = sh[j]; in_op = ops[j]; in_tag = 4'(j);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_zero_shift();
    out_ready = 1'b1;
    for (int j = 0; j < STG8 + 5; j++) begin
      @(negedge clk);
      if (j >= STG8 && j < STG8 + 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid[%0d]: got %b expected 1", j-STG8, out_valid); end
        checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL zero_data[%0d]: got %h expected 5a", j-STG8, out_data); end
        checks++; if (out_op !== exp_op(2'(j - STG8))) begin errors++; $display("FAIL zero_op[%0d]: got %0d expected %0d", j-STG8, out_op, exp_op(2'(j-STG8))); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_idle[%0d]: got %b expected 0", j, out_valid); end
      end
      if (j < 4) begin
        in_valid = 1'b1; in_data = 8'h5A; in_shamt = 4'd0; in_op = 2'(j); in_tag = 4'(j);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         rcvd = 0;
    int         hold = 0;
    int         cyc  = 0;
    logic       started = 1'b0;
    logic [7:0] hd, src, exd;
    logic [3:0] ht;
    logic       acc, ohs;
    out_ready = 1'b1;
    while (rcvd < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !started) begin
        started = 1'b1; hold = 5; hd = out_data; ht = out_tag;
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        if (hold < 5) begin
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
          checks++; if (out_data !== hd) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", out_data, hd); end
          checks++; if (out_tag !== ht) begin errors++; $display("FAIL bp_hold_tag: got %h expected %h", out_tag, ht); end
        end
        hold--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 10);
      in_tag   = 4'(sent);
      in_data  = 8'(sent * 19 + 1);
      in_shamt = 4'd1;
      in_op    = 2'd0;
      #1;
      if (!out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      end
      ohs = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (ohs) begin
        src = 8'(rcvd * 19 + 1);
        exd = src << 1;
        checks++; if (out_tag !== 4'(rcvd)) begin errors++; $display("FAIL bp_tag_order: got %h expected %h", out_tag, 4'(rcvd)); end
        checks++; if (out_data !== exd) begin errors++; $display("FAIL bp_data: got %h expected %h", out_data, exd); end
        rcvd++;
      end
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcvd != 10) begin errors++; $display("FAIL bp_count: got %0d results expected 10", rcvd); end
  endtask

  // Reset lands while the oldest op is handshaking; that handshake is dropped too.
  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hFF; in_shamt = 4'd0; in_op = 2'd2; in_tag = 4'(4'hA + j);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", out_data); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL rstmid_tag: got %h expected 0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost[%0d]: got valid %b tag %h expected no output", j, out_valid, out_tag); end
    end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  t;
    logic [1:0]  op;
  } exp_t;

  task automatic test_width32();
    localparam int NR = 400;
    exp_t q[$];
    exp_t e;
    int   sent = 0;
    int   rcvd = 0;
    int   cyc  = 0;
    w_out_ready = 1'b1;
    for (int j = 0; j < STG32 + 3; j++) begin
      @(negedge clk);
      checks++; if (w_out_valid !== (j == STG32)) begin errors++; $display("FAIL w32_latency[%0d]: got %b expected %b", j, w_out_valid, (j == STG32)); end
      if (j == STG32) begin
        checks++; if (w_out_data !== 32'hF800_0000) begin errors++; $display("FAIL w32_sra_data: got %h expected f8000000", w_out_data); end
        checks++; if (w_out_tag !== 8'h5A) begin errors++; $display("FAIL w32_tag: got %h expected 5a", w_out_tag); end
      end
      w_in_valid = (j == 0); w_in_data = 32'h8000_0001; w_in_shamt = 6'd4; w_in_op = 2'd2; w_in_tag = 8'h5A;
    end
    while ((sent < NR || rcvd < sent) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      w_out_ready = ($urandom_range(0, 3) != 0);
      w_in_valid  = (sent < NR) && ($urandom_range(0, 3) != 0);
      w_in_data   = $urandom;
      w_in_shamt  = 6'($urandom_range(0, 63));
      w_in_op     = 2'($urandom_range(0, 3));
      w_in_tag    = 8'(sent);
      #1;
      if (w_out_valid && w_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL w32_unexpected: got tag %h expected no output", w_out_tag);
        end else begin
          e = q.pop_front();
          if (w_out_data !== e.d || w_out_tag !== e.t || w_out_op !== e.op) begin
            errors++;
            $display("FAIL w32_model: got %h/%h/%0d expected %h/%h/%0d", w_out_data, w_out_tag, w_out_op, e.d, e.t, e.op);
          end
          rcvd++;
        end
      end
      if (w_in_valid && w_in_ready) begin
        e.d = model32(w_in_data, w_in_shamt, w_in_op); e.t = w_in_tag; e.op = exp_op(w_in_op);
        q.push_back(e);
        sent++;
      end
    end
    w_in_valid = 1'b0;
    checks++; if (rcvd != NR) begin errors++; $display("FAIL w32_count: got %0d results expected %0d", rcvd, NR); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_shamt = '0; w_in_op = '0; w_in_tag = '0; w_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_out_of_range();
    test_zero_shift();
    test_backpressure();
    test_reset_mid();
    test_width32();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
